// File: rtl/alu64_arbiter.sv
// Round-robin two-port front end for a shared 64-bit ALU.
// A request is registered into the ALU, the result is captured, and it is returned on the granted port.
module alu64_arbiter #(
   parameter int unsigned W = 64
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req_valid_0,
   input  logic         req_valid_1,
   output logic         req_ready_0,
   output logic         req_ready_1,
   input  logic [W-1:0] req_a_0,
   input  logic [W-1:0] req_b_0,
   input  logic [W-1:0] req_a_1,
   input  logic [W-1:0] req_b_1,
   input  logic [3:0]   req_op_0,
   input  logic [3:0]   req_op_1,
   output logic         rsp_valid_0,
   output logic         rsp_valid_1,
   input  logic         rsp_ready_0,
   input  logic         rsp_ready_1,
   output logic [W-1:0] rsp_result,
   output logic         rsp_zero,
   output logic         rsp_err,
   output logic [W-1:0] alu_a,
   output logic [W-1:0] alu_b,
   output logic [3:0]   alu_op,
   input  logic [W-1:0] alu_result,
   input  logic         alu_zero,
   output logic         busy,
   output logic [31:0]  ops_done
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t       state_q, state_d;
   logic         last_grant_q, last_grant_d;
   logic         gnt_q, gnt_d;
   logic         err_q, err_d;
   logic [W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic [3:0]   alu_op_q, alu_op_d;
   logic [W-1:0] rsp_result_q, rsp_result_d;
   logic         rsp_zero_q, rsp_zero_d;
   logic         rsp_err_q, rsp_err_d;
   logic [31:0]  ops_done_q, ops_done_d;

   logic         grant;
   logic         req_hs;
   logic         rsp_hs;
   logic [3:0]   op_sel;
   logic         op_illegal;

   always_comb begin
      // A tie goes to the port that did not win last time.
      grant = 1'b0;
      if (req_valid_0 && req_valid_1) begin
         grant = ~last_grant_q;
      end else if (req_valid_1) begin
         grant = 1'b1;
      end
      req_ready_0 = (state_q == IDLE) && req_valid_0 && !grant;
      req_ready_1 = (state_q == IDLE) && req_valid_1 && grant;
      req_hs      = req_ready_0 || req_ready_1;
      rsp_valid_0 = (state_q == RESP) && !gnt_q;
      rsp_valid_1 = (state_q == RESP) && gnt_q;
      rsp_hs      = (rsp_valid_0 && rsp_ready_0) || (rsp_valid_1 && rsp_ready_1);
      op_sel      = grant ? req_op_1 : req_op_0;
      case (op_sel)
         4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100: op_illegal = 1'b0;
         default:                                     op_illegal = 1'b1;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      gnt_d        = gnt_q;
      err_d        = err_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_op_d     = alu_op_q;
      rsp_result_d = rsp_result_q;
      rsp_zero_d   = rsp_zero_q;
      rsp_err_d    = rsp_err_q;
      ops_done_d   = ops_done_q;
      case (state_q)
         IDLE: begin
            if (req_hs) begin
               alu_a_d      = grant ? req_a_1 : req_a_0;
               alu_b_d      = grant ? req_b_1 : req_b_0;
               alu_op_d     = op_sel;
               gnt_d        = grant;
               last_grant_d = grant;
               err_d        = op_illegal;
               state_d      = EXEC;
            end
         end
         EXEC: begin
            rsp_result_d = alu_result;
            rsp_zero_d   = alu_zero;
            rsp_err_d    = err_q;
            state_d      = RESP;
         end
         RESP: begin
            if (rsp_hs) begin
               ops_done_d = ops_done_q + 32'd1;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         gnt_q        <= 1'b0;
         err_q        <= 1'b0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_op_q     <= '0;
         rsp_result_q <= '0;
         rsp_zero_q   <= 1'b0;
         rsp_err_q    <= 1'b0;
         ops_done_q   <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         gnt_q        <= gnt_d;
         err_q        <= err_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_op_q     <= alu_op_d;
         rsp_result_q <= rsp_result_d;
         rsp_zero_q   <= rsp_zero_d;
         rsp_err_q    <= rsp_err_d;
         ops_done_q   <= ops_done_d;
      end
   end

   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_op     = alu_op_q;
   assign rsp_result = rsp_result_q;
   assign rsp_zero   = rsp_zero_q;
   assign rsp_err    = rsp_err_q;
   assign busy       = (state_q != IDLE);
   assign ops_done   = ops_done_q;

endmodule

// File: tb/tb_alu64_arbiter.sv
// Directed bench for alu64_arbiter with a behavioural ALU on the alu_* side.
module tb_alu64_arbiter;
   localparam int unsigned W = 64;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         req_valid_0, req_valid_1, req_ready_0, req_ready_1;
   logic [W-1:0] req_a_0, req_b_0, req_a_1, req_b_1;
   logic [3:0]   req_op_0, req_op_1;
   logic         rsp_valid_0, rsp_valid_1, rsp_ready_0, rsp_ready_1;
   logic [W-1:0] rsp_result;
   logic         rsp_zero, rsp_err;
   logic [W-1:0] alu_a, alu_b, alu_result;
   logic [3:0]   alu_op;
   logic         alu_zero, busy;
   logic [31:0]  ops_done;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_ops;

   typedef struct {
      logic        port;
      logic [63:0] a;
      logic [63:0] b;
      logic [3:0]  op;
      logic [63:0] res;
      logic        zero;
      logic        err;
   } vec_t;

   vec_t vecs [8];

   alu64_arbiter #(.W(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
      .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
      .req_a_0(req_a_0), .req_b_0(req_b_0), .req_a_1(req_a_1), .req_b_1(req_b_1),
      .req_op_0(req_op_0), .req_op_1(req_op_1),
      .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
      .rsp_ready_0(rsp_ready_0), .rsp_ready_1(rsp_ready_1),
      .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_result(alu_result), .alu_zero(alu_zero),
      .busy(busy), .ops_done(ops_done)
   );

   always #5 clk = ~clk;

   always_comb begin
      case (alu_op)
         4'b0000: alu_result = alu_a & alu_b;
         4'b0001: alu_result = alu_a | alu_b;
         4'b0010: alu_result = alu_a + alu_b;
         4'b0110: alu_result = alu_a - alu_b;
         4'b1100: alu_result = ~(alu_a | alu_b);
         default: alu_result = '0;
      endcase
      alu_zero = (alu_result == '0);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0b expected %0b", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      req_valid_0 = 1'b0; req_valid_1 = 1'b0;
      req_a_0 = '0; req_b_0 = '0; req_op_0 = '0;
      req_a_1 = '0; req_b_1 = '0; req_op_1 = '0;
      rsp_ready_0 = 1'b0; rsp_ready_1 = 1'b0;
   endtask

   task automatic drive_req(input logic port, input logic [63:0] a, input logic [63:0] b,
                            input logic [3:0] op);
      if (port) begin
         req_valid_1 = 1'b1; req_a_1 = a; req_b_1 = b; req_op_1 = op;
      end else begin
         req_valid_0 = 1'b1; req_a_0 = a; req_b_0 = b; req_op_0 = op;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk1($sformatf("%s.busy", tag), busy, 1'b0);
      chk1($sformatf("%s.rsp_valid_0", tag), rsp_valid_0, 1'b0);
      chk1($sformatf("%s.rsp_valid_1", tag), rsp_valid_1, 1'b0);
      chk($sformatf("%s.ops_done", tag), {32'd0, ops_done}, 64'd0);
      chk($sformatf("%s.alu_a", tag), alu_a, 64'd0);
      chk($sformatf("%s.alu_b", tag), alu_b, 64'd0);
      chk($sformatf("%s.alu_op", tag), {60'd0, alu_op}, 64'd0);
      chk($sformatf("%s.rsp_result", tag), rsp_result, 64'd0);
      chk1($sformatf("%s.rsp_zero", tag), rsp_zero, 1'b0);
      chk1($sformatf("%s.rsp_err", tag), rsp_err, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      clear_inputs();
      rst_n   = 1'b0;
      exp_ops = '0;
      #1;
      check_reset_outputs("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One complete transaction on a single port; leaves the DUT idle at a falling edge.
   task automatic run_op(input int idx, input vec_t v);
      @(negedge clk);
      drive_req(v.port, v.a, v.b, v.op);
      #1;
      chk1($sformatf("v%0d.req_ready_gnt", idx), v.port ? req_ready_1 : req_ready_0, 1'b1);
      chk1($sformatf("v%0d.req_ready_oth", idx), v.port ? req_ready_0 : req_ready_1, 1'b0);
      @(posedge clk);
      @(negedge clk);
      req_valid_0 = 1'b0; req_valid_1 = 1'b0;
      #1;
      chk1($sformatf("v%0d.exec_busy", idx), busy, 1'b1);
      chk1($sformatf("v%0d.exec_rsp_valid", idx), rsp_valid_0 | rsp_valid_1, 1'b0);
      chk($sformatf("v%0d.alu_a", idx), alu_a, v.a);
      chk($sformatf("v%0d.alu_op", idx), {60'd0, alu_op}, {60'd0, v.op});
      @(negedge clk);
      #1;
      chk1($sformatf("v%0d.rsp_valid_gnt", idx), v.port ? rsp_valid_1 : rsp_valid_0, 1'b1);
      chk1($sformatf("v%0d.rsp_valid_oth", idx), v.port ? rsp_valid_0 : rsp_valid_1, 1'b0);
      chk($sformatf("v%0d.result", idx), rsp_result, v.res);
      chk1($sformatf("v%0d.zero", idx), rsp_zero, v.zero);
      chk1($sformatf("v%0d.err", idx), rsp_err, v.err);
      if (v.port) rsp_ready_1 = 1'b1; else rsp_ready_0 = 1'b1;
      @(posedge clk);
      exp_ops = exp_ops + 32'd1;
      @(negedge clk);
      rsp_ready_0 = 1'b0; rsp_ready_1 = 1'b0;
      #1;
      chk1($sformatf("v%0d.idle_busy", idx), busy, 1'b0);
      chk($sformatf("v%0d.ops_done", idx), {32'd0, ops_done}, {32'd0, exp_ops});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{1'b0, 64'd5, 64'd7, 4'b0010, 64'd12, 1'b0, 1'b0};
      vecs[1] = '{1'b1, 64'h1234, 64'h1234, 4'b0110, 64'd0, 1'b1, 1'b0};
      vecs[2] = '{1'b0, 64'd9, 64'd3, 4'b0101, 64'd0, 1'b1, 1'b1};
      vecs[3] = '{1'b1, 64'hF0, 64'h0F, 4'b0001, 64'hFF, 1'b0, 1'b0};
      vecs[4] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0010, 64'd0, 1'b1, 1'b0};
      vecs[5] = '{1'b1, 64'd3, 64'd5, 4'b0110, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
      vecs[6] = '{1'b0, 64'd0, 64'd0, 4'b1100, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
      vecs[7] = '{1'b1, 64'hF0, 64'h3C, 4'b0000, 64'h30, 1'b0, 1'b0};

      clear_inputs();
      rst_n = 1'b1;
      exp_ops = '0;
      do_reset();

      for (int i = 0; i < 8; i++) run_op(i, vecs[i]);

      // Both ports valid continuously with responses always accepted.
      do_reset();
      drive_req(1'b0, 64'hF0, 64'h3C, 4'b0000);
      drive_req(1'b1, 64'h0, 64'h0, 4'b1100);
      rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk1($sformatf("tie%0d.req_ready_0", i), req_ready_0, (i % 2) == 0);
         chk1($sformatf("tie%0d.req_ready_1", i), req_ready_1, (i % 2) == 1);
         @(posedge clk);
         @(negedge clk);
         #1;
         chk1($sformatf("tie%0d.exec_rdy", i), req_ready_0 | req_ready_1, 1'b0);
         @(negedge clk);
         #1;
         chk1($sformatf("tie%0d.rsp_valid_0", i), rsp_valid_0, (i % 2) == 0);
         chk1($sformatf("tie%0d.rsp_valid_1", i), rsp_valid_1, (i % 2) == 1);
         chk1($sformatf("tie%0d.resp_rdy", i), req_ready_0 | req_ready_1, 1'b0);
         chk($sformatf("tie%0d.result", i), rsp_result,
             (i % 2) == 0 ? 64'h30 : 64'hFFFF_FFFF_FFFF_FFFF);
         @(posedge clk);
         exp_ops = exp_ops + 32'd1;
         @(negedge clk);
      end
      #1;
      chk("tie.ops_done", {32'd0, ops_done}, {32'd0, exp_ops});
      clear_inputs();

      // Response back-pressure on port 0 while port 1 waits.
      @(negedge clk);
      drive_req(1'b0, 64'd1, 64'd2, 4'b0010);
      #1;
      chk1("bp.req_ready_0", req_ready_0, 1'b1);
      @(posedge clk);
      @(negedge clk);
      req_valid_0 = 1'b0;
      drive_req(1'b1, 64'd9, 64'd4, 4'b0110);
      rsp_ready_1 = 1'b1;
      #1;
      chk1("bp.exec_req_ready_1", req_ready_1, 1'b0);
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         #1;
         chk1($sformatf("bp%0d.rsp_valid_0", k), rsp_valid_0, 1'b1);
         chk1($sformatf("bp%0d.rsp_valid_1", k), rsp_valid_1, 1'b0);
         chk($sformatf("bp%0d.result", k), rsp_result, 64'd3);
         chk1($sformatf("bp%0d.zero", k), rsp_zero, 1'b0);
         chk1($sformatf("bp%0d.err", k), rsp_err, 1'b0);
         chk1($sformatf("bp%0d.req_ready_1", k), req_ready_1, 1'b0);
         if (k == 4) rsp_ready_0 = 1'b1;
         @(posedge clk);
         @(negedge clk);
      end
      exp_ops = exp_ops + 32'd1;
      rsp_ready_0 = 1'b0;
      #1;
      chk1("bp.idle_req_ready_1", req_ready_1, 1'b1);
      chk1("bp.idle_req_ready_0", req_ready_0, 1'b0);
      chk("bp.ops_done", {32'd0, ops_done}, {32'd0, exp_ops});
      @(posedge clk);
      @(negedge clk);
      req_valid_1 = 1'b0;
      @(negedge clk);
      #1;
      chk1("bp.p1_rsp_valid_1", rsp_valid_1, 1'b1);
      chk("bp.p1_result", rsp_result, 64'd5);
      @(posedge clk);
      exp_ops = exp_ops + 32'd1;
      @(negedge clk);
      rsp_ready_1 = 1'b0;
      #1;
      chk("bp.p1_ops_done", {32'd0, ops_done}, {32'd0, exp_ops});

      // Reset asserted while the operation is in EXEC.
      @(negedge clk);
      drive_req(1'b0, 64'd5, 64'd7, 4'b0010);
      @(posedge clk);
      @(negedge clk);
      req_valid_0 = 1'b0;
      #1;
      chk1("mid.exec_busy", busy, 1'b1);
      rst_n   = 1'b0;
      exp_ops = '0;
      #1;
      check_reset_outputs("mid");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      drive_req(1'b0, 64'd5, 64'd7, 4'b0010);
      drive_req(1'b1, 64'h1, 64'h2, 4'b0001);
      #1;
      chk1("mid.tie_ready_0", req_ready_0, 1'b1);
      chk1("mid.tie_ready_1", req_ready_1, 1'b0);
      @(posedge clk);
      @(negedge clk);
      req_valid_0 = 1'b0; req_valid_1 = 1'b0;
      @(negedge clk);
      #1;
      chk1("mid.rsp_valid_0", rsp_valid_0, 1'b1);
      chk("mid.result", rsp_result, 64'd12);
      rsp_ready_0 = 1'b1;
      @(posedge clk);
      exp_ops = exp_ops + 32'd1;
      @(negedge clk);
      rsp_ready_0 = 1'b0;
      #1;
      chk("mid.ops_done", {32'd0, ops_done}, {32'd0, exp_ops});

      // Counter wrap from all-ones.
      @(negedge clk);
      force dut.ops_done_q = 32'hFFFF_FFFF;
      @(posedge clk);
      @(negedge clk);
      release dut.ops_done_q;
      #1;
      chk("wrap.preset", {32'd0, ops_done}, 64'hFFFF_FFFF);
      exp_ops = 32'hFFFF_FFFF;
      run_op(8, vecs[0]);
      chk("wrap.zero", {32'd0, ops_done}, 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
